// File: rtl/cc_collision_monitor.sv
// cc_collision_monitor: sequential collision/goal detector for the frog playfield.
// On START it snapshots the frog/background bitmaps and screen state, scans one
// row per clock, then classifies the frame as crash (after HOLD_SCANS consecutive
// crashing scans), goal or nothing. A nonzero result is held until ACK.
// Ports:
//   CLOCK_50 / RESET_InLow         : clock, synchronous active-low reset
//   FROG_In_Bus / BACKGROUND_In_Bus: flattened row bitmaps (row r = [r*W +: W])
//   IMAGE_InBus                    : screen state, 2'b10 suppresses detection
//   START_In / ACK_In              : scan request / result consume
//   RESULT_Out_Bus                 : 00 none, 01 crash, 10 goal
//   VALID_Out                      : result pending until ACK
//   LOCATION_Out                   : frog present in ZONE_MASK rows at last scan
//   CRASHROW_Out_Bus               : lowest crashing row of the reported crash
//   BUSY_Out                       : scan/evaluate in progress
module cc_collision_monitor #(
    parameter int unsigned          DATAWIDTH_BUS = 8,
    parameter int unsigned          NUM_ROWS      = 16,
    parameter logic [NUM_ROWS-1:0]  HAZARD_MASK   = 16'b0011_1110_0111_1100,
    parameter int unsigned          GOAL_ROW      = 14,
    parameter logic [NUM_ROWS-1:0]  ZONE_MASK     = 16'b0111_1111_1000_0000,
    parameter int unsigned          HOLD_SCANS    = 2
) (
    input  logic                                CC_COLLISIONMONITOR_CLOCK_50,
    input  logic                                CC_COLLISIONMONITOR_RESET_InLow,
    input  logic [NUM_ROWS*DATAWIDTH_BUS-1:0]   CC_COLLISIONMONITOR_FROG_In_Bus,
    input  logic [NUM_ROWS*DATAWIDTH_BUS-1:0]   CC_COLLISIONMONITOR_BACKGROUND_In_Bus,
    input  logic [1:0]                          CC_COLLISIONMONITOR_IMAGE_InBus,
    input  logic                                CC_COLLISIONMONITOR_START_In,
    input  logic                                CC_COLLISIONMONITOR_ACK_In,
    output logic [1:0]                          CC_COLLISIONMONITOR_RESULT_Out_Bus,
    output logic                                CC_COLLISIONMONITOR_VALID_Out,
    output logic                                CC_COLLISIONMONITOR_LOCATION_Out,
    output logic [$clog2(NUM_ROWS)-1:0]         CC_COLLISIONMONITOR_CRASHROW_Out_Bus,
    output logic                                CC_COLLISIONMONITOR_BUSY_Out
);

    localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
    localparam int unsigned BUS_W  = NUM_ROWS * DATAWIDTH_BUS;
    localparam int unsigned HOLD_W = $clog2(HOLD_SCANS + 1);

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_CRASH = 2'b01;
    localparam logic [1:0] RES_GOAL  = 2'b10;
    localparam logic [1:0] IMG_SUPPR = 2'b10;

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, REPORT} state_t;

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   frog_q, frog_d;
    logic [BUS_W-1:0]   bg_q, bg_d;
    logic [1:0]         image_q, image_d;
    logic [ROW_W-1:0]   idx_q, idx_d;
    logic               crash_hit_q, crash_hit_d;
    logic               goal_hit_q, goal_hit_d;
    logic               loc_acc_q, loc_acc_d;
    logic [ROW_W-1:0]   crash_rec_q, crash_rec_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]         result_q, result_d;
    logic               valid_q, valid_d;
    logic               location_q, location_d;
    logic [ROW_W-1:0]   crashrow_q, crashrow_d;
    logic               busy_q, busy_d;

    logic [DATAWIDTH_BUS-1:0] frog_row, bg_row;
    logic                     row_crash, row_goal, row_loc;

    // Current row of the snapshot and its per-row classification
    always_comb begin
        logic is_goal_row;
        logic row_nz;
        logic covered;
        frog_row    = frog_q[idx_q*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        bg_row      = bg_q[idx_q*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        is_goal_row = (idx_q == ROW_W'(GOAL_ROW));
        row_nz      = |frog_row;
        covered     = ((frog_row | bg_row) == bg_row);
        row_crash   = (HAZARD_MASK[idx_q] | is_goal_row) & row_nz & covered;
        row_goal    = is_goal_row & row_nz & ~covered;
        row_loc     = ZONE_MASK[idx_q] & row_nz;
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        frog_d      = frog_q;
        bg_d        = bg_q;
        image_d     = image_q;
        idx_d       = idx_q;
        crash_hit_d = crash_hit_q;
        goal_hit_d  = goal_hit_q;
        loc_acc_d   = loc_acc_q;
        crash_rec_d = crash_rec_q;
        hold_cnt_d  = hold_cnt_q;
        result_d    = result_q;
        valid_d     = valid_q;
        location_d  = location_q;
        crashrow_d  = crashrow_q;
        busy_d      = (state_q == SCAN);

        unique case (state_q)
            IDLE: begin
                if (CC_COLLISIONMONITOR_START_In) begin
                    frog_d      = CC_COLLISIONMONITOR_FROG_In_Bus;
                    bg_d        = CC_COLLISIONMONITOR_BACKGROUND_In_Bus;
                    image_d     = CC_COLLISIONMONITOR_IMAGE_InBus;
                    idx_d       = '0;
                    crash_hit_d = 1'b0;
                    goal_hit_d  = 1'b0;
                    loc_acc_d   = 1'b0;
                    crash_rec_d = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                // Only the first (lowest) crashing row is kept
                if (row_crash && !crash_hit_q) begin
                    crash_rec_d = idx_q;
                end
                crash_hit_d = crash_hit_q | row_crash;
                goal_hit_d  = goal_hit_q | row_goal;
                loc_acc_d   = loc_acc_q | row_loc;
                if (idx_q == ROW_W'(NUM_ROWS - 1)) begin
                    state_d = EVAL;
                end else begin
                    idx_d = idx_q + ROW_W'(1);
                end
            end
            EVAL: begin
                location_d = loc_acc_q;
                result_d   = RES_NONE;
                hold_cnt_d = '0;
                if (image_q == IMG_SUPPR) begin
                    result_d = RES_NONE;
                end else if (crash_hit_q) begin
                    // Crash must persist; an unconfirmed crash still masks goal
                    if (hold_cnt_q >= HOLD_W'(HOLD_SCANS - 1)) begin
                        result_d   = RES_CRASH;
                        crashrow_d = crash_rec_q;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (goal_hit_q) begin
                    result_d = RES_GOAL;
                end
                valid_d = (result_d != RES_NONE);
                state_d = (result_d != RES_NONE) ? REPORT : IDLE;
            end
            REPORT: begin
                if (CC_COLLISIONMONITOR_ACK_In) begin
                    result_d = RES_NONE;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge CC_COLLISIONMONITOR_CLOCK_50) begin
        if (!CC_COLLISIONMONITOR_RESET_InLow) begin
            state_q     <= IDLE;
            frog_q      <= '0;
            bg_q        <= '0;
            image_q     <= '0;
            idx_q       <= '0;
            crash_hit_q <= 1'b0;
            goal_hit_q  <= 1'b0;
            loc_acc_q   <= 1'b0;
            crash_rec_q <= '0;
            hold_cnt_q  <= '0;
            result_q    <= RES_NONE;
            valid_q     <= 1'b0;
            location_q  <= 1'b0;
            crashrow_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frog_q      <= frog_d;
            bg_q        <= bg_d;
            image_q     <= image_d;
            idx_q       <= idx_d;
            crash_hit_q <= crash_hit_d;
            goal_hit_q  <= goal_hit_d;
            loc_acc_q   <= loc_acc_d;
            crash_rec_q <= crash_rec_d;
            hold_cnt_q  <= hold_cnt_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            location_q  <= location_d;
            crashrow_q  <= crashrow_d;
            busy_q      <= busy_d;
        end
    end

    assign CC_COLLISIONMONITOR_RESULT_Out_Bus   = result_q;
    assign CC_COLLISIONMONITOR_VALID_Out        = valid_q;
    assign CC_COLLISIONMONITOR_LOCATION_Out     = location_q;
    assign CC_COLLISIONMONITOR_CRASHROW_Out_Bus = crashrow_q;
    assign CC_COLLISIONMONITOR_BUSY_Out         = busy_q;

endmodule

// File: tb/tb_cc_collision_monitor.sv
// Testbench for cc_collision_monitor: directed scenarios plus randomized scans
// checked against a row-rule reference model with a persistence counter.
module tb_cc_collision_monitor;

    localparam int W    = 8;
    localparam int ROWS = 16;
    localparam int GOAL = 14;
    localparam int HOLD = 2;

    logic             clk;
    logic             rst_n;
    logic [ROWS*W-1:0] frog;
    logic [ROWS*W-1:0] bg;
    logic [1:0]       img;
    logic             start;
    logic             ack;
    logic [1:0]       result;
    logic             valid;
    logic             location;
    logic [3:0]       crashrow;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_hold     = 0;
    int m_res      = 0;
    int m_loc      = 0;
    int m_crashrow = 0;

    logic [15:0] haz  = 16'b0011_1110_0111_1100;
    logic [15:0] zone = 16'b0111_1111_1000_0000;

    cc_collision_monitor dut (
        .CC_COLLISIONMONITOR_CLOCK_50         (clk),
        .CC_COLLISIONMONITOR_RESET_InLow      (rst_n),
        .CC_COLLISIONMONITOR_FROG_In_Bus      (frog),
        .CC_COLLISIONMONITOR_BACKGROUND_In_Bus(bg),
        .CC_COLLISIONMONITOR_IMAGE_InBus      (img),
        .CC_COLLISIONMONITOR_START_In         (start),
        .CC_COLLISIONMONITOR_ACK_In           (ack),
        .CC_COLLISIONMONITOR_RESULT_Out_Bus   (result),
        .CC_COLLISIONMONITOR_VALID_Out        (valid),
        .CC_COLLISIONMONITOR_LOCATION_Out     (location),
        .CC_COLLISIONMONITOR_CRASHROW_Out_Bus (crashrow),
        .CC_COLLISIONMONITOR_BUSY_Out         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classify a frame from the row rules, then apply the persistence counter
    task automatic model_eval(input logic [ROWS*W-1:0] f, input logic [ROWS*W-1:0] b,
                              input logic [1:0] im);
        bit crash = 0;
        bit goal  = 0;
        int first = -1;
        logic [7:0] fr, br;
        m_loc = 0;
        for (int r = 0; r < ROWS; r++) begin
            fr = f[r*W +: W];
            br = b[r*W +: W];
            if ((haz[r] || r == GOAL) && fr != 0 && (fr & ~br) == 0) begin
                crash = 1;
                if (first < 0) first = r;
            end
            if (r == GOAL && fr != 0 && (fr & ~br) != 0) goal = 1;
            if (zone[r] && fr != 0) m_loc = 1;
        end
        m_res = 0;
        if (im == 2'b10) begin
            m_hold = 0;
        end else if (crash) begin
            m_hold = m_hold + 1;
            if (m_hold >= HOLD) begin
                m_res      = 1;
                m_crashrow = first;
                m_hold     = 0;
            end
        end else if (goal) begin
            m_res  = 2;
            m_hold = 0;
        end else begin
            m_hold = 0;
        end
    endtask

    // One full scan from the IDLE state; optionally scramble inputs after START
    task automatic do_scan(input string tag, input logic [ROWS*W-1:0] f,
                           input logic [ROWS*W-1:0] b, input logic [1:0] im, input bit scr);
        @(negedge clk);
        frog = f; bg = b; img = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scr) begin
            for (int i = 0; i < ROWS; i++) begin
                frog[i*W +: W] = 8'($urandom);
                bg[i*W +: W]   = 8'($urandom);
            end
            img = 2'($urandom_range(0, 3));
        end
        model_eval(f, b, im);
        @(posedge clk); #1;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        repeat (ROWS - 1) @(posedge clk);
        #1;
        check({tag, ".valid_early"}, 32'(valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".result"},   32'(result),   32'(m_res));
        check({tag, ".valid"},    32'(valid),    32'(m_res != 0));
        check({tag, ".location"}, 32'(location), 32'(m_loc));
        check({tag, ".crashrow"}, 32'(crashrow), 32'(m_crashrow));
        check({tag, ".busy_fall"}, 32'(busy),    32'd0);
    endtask

    // In REPORT: a lone START is dropped, then ACK (optionally with START) clears
    task automatic do_ack(input string tag, input bit with_start);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".held_valid"},  32'(valid),  32'd1);
        check({tag, ".held_result"}, 32'(result), 32'(m_res));
        check({tag, ".no_busy"},     32'(busy),   32'd0);
        @(negedge clk);
        ack = 1'b1; start = with_start;
        @(posedge clk); #1;
        ack = 1'b0; start = 1'b0;
        check({tag, ".ack_valid"},    32'(valid),    32'd0);
        check({tag, ".ack_result"},   32'(result),   32'd0);
        check({tag, ".ack_crashrow"}, 32'(crashrow), 32'(m_crashrow));
        @(posedge clk); #1;
        check({tag, ".start_dropped"}, 32'(busy), 32'd0);
        m_res = 0;
    endtask

    function automatic logic [ROWS*W-1:0] row_set(input logic [ROWS*W-1:0] v, input int r,
                                                   input logic [7:0] x);
        logic [ROWS*W-1:0] t = v;
        t[r*W +: W] = x;
        return t;
    endfunction

    logic [ROWS*W-1:0] f0, b0, f1, b1;
    logic [1:0]        im0;

    initial begin
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; frog = '0; bg = '0; img = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset.result",   32'(result),   32'd0);
        check("reset.valid",    32'(valid),    32'd0);
        check("reset.location", 32'(location), 32'd0);
        check("reset.crashrow", 32'(crashrow), 32'd0);
        check("reset.busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Persistent crash on row 3
        f0 = row_set('0, 3, 8'h18);
        b0 = row_set('0, 3, 8'hFF);
        do_scan("persist1", f0, b0, 2'b00, 0);
        do_scan("persist2", f0, b0, 2'b00, 0);
        check("persist.crashrow3", 32'(crashrow), 32'd3);
        do_ack("persist_ack", 1);

        // Transient crash: crash, clean, crash -> no report
        do_scan("trans1", f0, b0, 2'b00, 0);
        do_scan("trans2", '0, b0, 2'b00, 0);
        do_scan("trans3", f0, b0, 2'b00, 0);

        // Goal on row 14 (clears the pending hold)
        f1 = row_set('0, 14, 8'h18);
        b1 = row_set('0, 14, 8'h81);
        do_scan("goal", f1, b1, 2'b00, 1);
        check("goal.result10", 32'(result), 32'd2);
        do_ack("goal_ack", 0);
        // Goal plus persistent row-5 crash: crash wins
        f1 = row_set(f1, 5, 8'h18);
        b1 = row_set(b1, 5, 8'hFF);
        do_scan("goalcrash1", f1, b1, 2'b00, 0);
        do_scan("goalcrash2", f1, b1, 2'b00, 0);
        check("goalcrash.crashrow5", 32'(crashrow), 32'd5);
        do_ack("goalcrash_ack", 1);

        // Suppression with IMAGE changing mid-scan
        do_scan("suppr1", f0, b0, 2'b10, 1);
        do_scan("suppr2", f0, b0, 2'b10, 1);
        do_scan("suppr3", f0, b0, 2'b00, 0);
        do_scan("suppr4", '0, '0, 2'b00, 0);

        // Safe row 7 sets location only; row 1 alone does not
        do_scan("safe7", row_set('0, 7, 8'h10), row_set('0, 7, 8'hFF), 2'b00, 0);
        do_scan("row1", row_set('0, 1, 8'h10), '0, 2'b00, 0);

        // Reset mid-scan with hold already at 1
        f1 = row_set(f0, 9, 8'h01);
        do_scan("pre_rst", f1, b0, 2'b00, 0);
        @(negedge clk);
        frog = f1; bg = b0; img = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst.result",   32'(result),   32'd0);
        check("midrst.valid",    32'(valid),    32'd0);
        check("midrst.location", 32'(location), 32'd0);
        check("midrst.crashrow", 32'(crashrow), 32'd0);
        check("midrst.busy",     32'(busy),     32'd0);
        m_hold = 0; m_res = 0; m_loc = 0; m_crashrow = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_scan("postrst1", f0, b0, 2'b00, 0);
        do_scan("postrst2", f0, b0, 2'b00, 0);
        do_ack("postrst_ack", 0);

        // Randomized scans, frequently repeating the previous frame
        f0 = '0; b0 = '0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0 || n == 0) begin
                for (int r = 0; r < ROWS; r++) begin
                    f0[r*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                    b0[r*W +: W] = ($urandom_range(0, 1) == 1) ? (f0[r*W +: W] | 8'($urandom))
                                                               : 8'($urandom);
                end
            end
            im0 = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            do_scan("rand", f0, b0, im0, 1);
            if (m_res != 0) do_ack("rand_ack", 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
